// File: rtl/issue_if.sv
// Handshake bundle between the issue queues and the issue scheduler,
// plus the CDB source select the scheduler drives back.
interface issue_if;
  logic       issueint_ready;
  logic       issuels_ready;
  logic       issuemult_ready;
  logic       issuediv_ready;
  logic       issueint_done;
  logic       issuels_done;
  logic       issuemult_done;
  logic       issuediv_done;
  logic [1:0] cdb_sel;
  logic       cdb_sel_valid;
  logic       div_busy;

  modport master (
    input  issueint_ready, issuels_ready, issuemult_ready, issuediv_ready,
    output issueint_done, issuels_done, issuemult_done, issuediv_done,
    output cdb_sel, cdb_sel_valid, div_busy
  );

  modport slave (
    output issueint_ready, issuels_ready, issuemult_ready, issuediv_ready,
    input  issueint_done, issuels_done, issuemult_done, issuediv_done,
    input  cdb_sel, cdb_sel_valid, div_busy
  );
endinterface

// File: rtl/issue_unit.sv
// Issue scheduler: grants each queue only when its future CDB slot is free and
// drives the CDB source select from a shifting slot-reservation vector.
module issue_unit #(
  parameter int INT_LAT  = 1,
  parameter int LS_LAT   = 1,
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 7
) (
  input  logic     clk,
  input  logic     reset,
  issue_if.master  iq
);

  localparam int CW = $clog2(DIV_LAT);

  typedef enum logic [1:0] {
    SRC_INT  = 2'd0,
    SRC_LS   = 2'd1,
    SRC_MULT = 2'd2,
    SRC_DIV  = 2'd3
  } src_e;

  logic [DIV_LAT:0]       resv_r, resv_set, resv_nxt;
  logic [DIV_LAT:0][1:0]  own_r, own_set, own_nxt;
  logic [CW-1:0]          div_cnt_r, div_cnt_nxt;
  logic                   lru_r, lru_nxt;
  logic                   pair_free;
  logic                   grant_int, grant_ls, grant_mult, grant_div;

  // int and ld/st share one CDB slot; lru_r breaks the tie when both are ready
  always_comb begin
    pair_free  = ~resv_r[INT_LAT];
    grant_int  = ~reset & iq.issueint_ready & pair_free &
                 (~iq.issuels_ready | ~lru_r);
    grant_ls   = ~reset & iq.issuels_ready & pair_free &
                 (~iq.issueint_ready | lru_r);
    grant_mult = ~reset & iq.issuemult_ready & ~resv_r[MULT_LAT];
    grant_div  = ~reset & iq.issuediv_ready & ~resv_r[DIV_LAT] &
                 (div_cnt_r == '0);
  end

  always_comb begin
    resv_set = resv_r;
    own_set  = own_r;
    if (grant_int) begin
      resv_set[INT_LAT] = 1'b1;
      own_set[INT_LAT]  = SRC_INT;
    end
    if (grant_ls) begin
      resv_set[LS_LAT] = 1'b1;
      own_set[LS_LAT]  = SRC_LS;
    end
    if (grant_mult) begin
      resv_set[MULT_LAT] = 1'b1;
      own_set[MULT_LAT]  = SRC_MULT;
    end
    if (grant_div) begin
      resv_set[DIV_LAT] = 1'b1;
      own_set[DIV_LAT]  = SRC_DIV;
    end
    // slot k becomes slot k-1 at the next edge; the farthest slot opens empty
    resv_nxt = {1'b0, resv_set[DIV_LAT:1]};
    own_nxt  = {2'b00, own_set[DIV_LAT:1]};

    lru_nxt = lru_r;
    if (grant_int)
      lru_nxt = 1'b1;
    else if (grant_ls)
      lru_nxt = 1'b0;

    div_cnt_nxt = div_cnt_r;
    if (grant_div)
      div_cnt_nxt = CW'(DIV_LAT - 1);
    else if (div_cnt_r != '0)
      div_cnt_nxt = div_cnt_r - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resv_r    <= '0;
      own_r     <= '0;
      div_cnt_r <= '0;
      lru_r     <= 1'b0;
    end else begin
      resv_r    <= resv_nxt;
      own_r     <= own_nxt;
      div_cnt_r <= div_cnt_nxt;
      lru_r     <= lru_nxt;
    end
  end

  assign iq.issueint_done  = grant_int;
  assign iq.issuels_done   = grant_ls;
  assign iq.issuemult_done = grant_mult;
  assign iq.issuediv_done  = grant_div;
  assign iq.cdb_sel_valid  = resv_r[0];
  assign iq.cdb_sel        = resv_r[0] ? own_r[0] : 2'd0;
  assign iq.div_busy       = (div_cnt_r != '0);

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios and random traffic checked against
// an absolute-time CDB calendar model.
module tb_issue_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  issue_if bus ();
  issue_unit dut (.clk(clk), .reset(reset), .iq(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // calendar: cal_v[c] = a result is on the CDB in absolute cycle c, from cal_o[c]
  bit       cal_v [0:2047];
  bit [1:0] cal_o [0:2047];
  int       div_next;
  bit       prefer_ls;

  bit [3:0] e_g;
  bit       e_valid;
  bit [1:0] e_sel;
  bit       e_busy;

  function automatic logic [3:0] act_g();
    return {bus.issueint_done, bus.issuels_done, bus.issuemult_done, bus.issuediv_done};
  endfunction

  task automatic model_clear();
    foreach (cal_v[i]) begin
      cal_v[i] = 1'b0;
      cal_o[i] = 2'd0;
    end
    div_next  = 0;
    prefer_ls = 1'b0;
  endtask

  // drive readies for this cycle and predict grants and CDB/busy state
  task automatic step(input bit ir, input bit lr, input bit mr, input bit dr);
    bit pair_free;
    bus.issueint_ready  = ir;
    bus.issuels_ready   = lr;
    bus.issuemult_ready = mr;
    bus.issuediv_ready  = dr;
    #1;
    pair_free = !cal_v[cyc+1];
    e_g[3]  = ir && pair_free && (!lr || !prefer_ls);
    e_g[2]  = lr && pair_free && (!ir || prefer_ls);
    e_g[1]  = mr && !cal_v[cyc+4];
    e_g[0]  = dr && !cal_v[cyc+7] && (cyc >= div_next);
    e_valid = cal_v[cyc];
    e_sel   = cal_v[cyc] ? cal_o[cyc] : 2'd0;
    e_busy  = (cyc < div_next);
  endtask

  task automatic advance();
    if (e_g[3]) begin cal_v[cyc+1] = 1'b1; cal_o[cyc+1] = 2'd0; prefer_ls = 1'b1; end
    if (e_g[2]) begin cal_v[cyc+1] = 1'b1; cal_o[cyc+1] = 2'd1; prefer_ls = 1'b0; end
    if (e_g[1]) begin cal_v[cyc+4] = 1'b1; cal_o[cyc+4] = 2'd2; end
    if (e_g[0]) begin cal_v[cyc+7] = 1'b1; cal_o[cyc+7] = 2'd3; div_next = cyc + 7; end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1);
    n_cmp++;
    if (act_g() !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_grants got=%b want=0000", act_g());
    end
    n_cmp++;
    if ({bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b want=0000",
               {bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy});
    end
    step(0, 0, 0, 0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    cyc = 0;
  endtask

  task automatic test_int_only();
    bit [3:0] stim [3] = '{4'b1000, 4'b0000, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL int_only_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel} !== {e_valid, e_sel}) begin
        n_bad++;
        $display("FAIL int_only_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel}, {e_valid, e_sel});
      end
      advance();
    end
  endtask

  task automatic test_lru_alternate();
    // leading ld/st-only cycle leaves int preferred for the contested run
    bit [3:0] stim [7] = '{4'b0100, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL lru_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel} !== {e_valid, e_sel}) begin
        n_bad++;
        $display("FAIL lru_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel}, {e_valid, e_sel});
      end
      advance();
    end
  endtask

  task automatic test_mult_blocks_int();
    bit [3:0] stim [8] = '{4'b0010, 4'b0000, 4'b0000, 4'b1000,
                           4'b1000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL mult_block_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel} !== {e_valid, e_sel}) begin
        n_bad++;
        $display("FAIL mult_block_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel}, {e_valid, e_sel});
      end
      advance();
    end
  endtask

  task automatic test_div_busy();
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 0, (i < 8));
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL div_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if (bus.div_busy !== e_busy) begin
        n_bad++;
        $display("FAIL div_busy t=%0d got=%b want=%b", i, bus.div_busy, e_busy);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel} !== {e_valid, e_sel}) begin
        n_bad++;
        $display("FAIL div_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel}, {e_valid, e_sel});
      end
      advance();
    end
  endtask

  task automatic test_all_three();
    for (int i = 0; i < 9; i++) begin
      if (i == 0) step(1, 0, 1, 1);
      else        step(0, 0, 0, 0);
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL all3_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel} !== {e_valid, e_sel}) begin
        n_bad++;
        $display("FAIL all3_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel}, {e_valid, e_sel});
      end
      advance();
    end
  endtask

  task automatic test_reset_midflight();
    step(0, 0, 1, 1);
    n_cmp++;
    if (act_g() !== e_g) begin
      n_bad++;
      $display("FAIL rstmid_grant got=%b want=%b", act_g(), e_g);
    end
    advance();
    step(0, 0, 0, 0);
    advance();
    bus.issueint_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({act_g(), bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy} !== 8'h00) begin
      n_bad++;
      $display("FAIL rstmid_outputs got=%b want=00000000",
               {act_g(), bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy});
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cyc++;
    for (int i = 0; i < 7; i++) begin
      step((i == 0), 0, 0, 0);
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL rstmid_after_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy} !== {e_valid, e_sel, e_busy}) begin
        n_bad++;
        $display("FAIL rstmid_after_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy}, {e_valid, e_sel, e_busy});
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30);
      n_cmp++;
      if (act_g() !== e_g) begin
        n_bad++;
        $display("FAIL rand_grant t=%0d got=%b want=%b", i, act_g(), e_g);
      end
      n_cmp++;
      if ({bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy} !== {e_valid, e_sel, e_busy}) begin
        n_bad++;
        $display("FAIL rand_cdb t=%0d got=%b want=%b", i,
                 {bus.cdb_sel_valid, bus.cdb_sel, bus.div_busy}, {e_valid, e_sel, e_busy});
      end
      advance();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.issueint_ready  = 1'b0;
    bus.issuels_ready   = 1'b0;
    bus.issuemult_ready = 1'b0;
    bus.issuediv_ready  = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_int_only();
    test_lru_alternate();
    test_mult_blocks_int();
    test_div_busy();
    test_all_three();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
